// File: rtl/regfile_port_sched_if.sv
// Requester and register-file port bundle for regfile_port_sched.
interface regfile_port_sched_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_W    = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_we;
  logic [NUM_REQ*ADDR_W-1:0]    req_addr;
  logic [NUM_REQ*WORD_SIZE-1:0] req_wdata;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ*WORD_SIZE-1:0] rsp_rdata;
  logic [ADDR_W-1:0]            rf_addr0;
  logic [ADDR_W-1:0]            rf_addr1;
  logic [WORD_SIZE-1:0]         rf_din0;
  logic [WORD_SIZE-1:0]         rf_din1;
  logic                         rf_we0;
  logic                         rf_we1;
  logic [WORD_SIZE-1:0]         rf_dout0;
  logic [WORD_SIZE-1:0]         rf_dout1;

  // Requesters plus register file, seen from outside the scheduler.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rf_dout0, rf_dout1,
    input  req_ready, rsp_valid, rsp_rdata, rf_addr0, rf_addr1, rf_din0, rf_din1,
    input  rf_we0, rf_we1
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rf_dout0, rf_dout1,
    output req_ready, rsp_valid, rsp_rdata, rf_addr0, rf_addr1, rf_din0, rf_din1,
    output rf_we0, rf_we1
  );
endinterface

// File: rtl/regfile_port_sched.sv
// Round-robin scheduler of NUM_REQ requesters onto the two register-file ports.
module regfile_port_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_W    = 4
) (
  input logic                clk,
  input logic                rst_n,
  regfile_port_sched_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic                         g0_vld, g1_vld;
  logic [PTR_W-1:0]             g0_idx, g1_idx, last_idx;
  int unsigned                  scan;
  logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

  // Scan from rr_ptr: first valid gets port 0, next eligible valid gets port 1.
  always_comb begin
    g0_vld = 1'b0;
    g0_idx = '0;
    g1_vld = 1'b0;
    g1_idx = '0;
    scan   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = 32'(rr_ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (bus.req_valid[scan]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = PTR_W'(scan);
        end else if (!g1_vld &&
                     !(bus.req_we[scan] && bus.req_we[g0_idx] &&
                       (bus.req_addr[scan*ADDR_W +: ADDR_W] ==
                        bus.req_addr[g0_idx*ADDR_W +: ADDR_W]))) begin
          // Two writes to one register in a cycle would race; defer the second.
          g1_vld = 1'b1;
          g1_idx = PTR_W'(scan);
        end
      end
    end
    // Nothing is granted while reset is held, even though rst_n is asynchronous.
    if (!rst_n) begin
      g0_vld = 1'b0;
      g1_vld = 1'b0;
    end
  end

  // Drive grants and register-file ports; idle ports are driven to zero.
  always_comb begin
    bus.req_ready = '0;
    bus.rf_addr0  = '0;
    bus.rf_we0    = 1'b0;
    bus.rf_din0   = '0;
    bus.rf_addr1  = '0;
    bus.rf_we1    = 1'b0;
    bus.rf_din1   = '0;
    if (g0_vld) begin
      bus.req_ready[g0_idx] = 1'b1;
      bus.rf_addr0 = bus.req_addr[g0_idx*ADDR_W +: ADDR_W];
      bus.rf_we0   = bus.req_we[g0_idx];
      if (bus.req_we[g0_idx]) bus.rf_din0 = bus.req_wdata[g0_idx*WORD_SIZE +: WORD_SIZE];
    end
    if (g1_vld) begin
      bus.req_ready[g1_idx] = 1'b1;
      bus.rf_addr1 = bus.req_addr[g1_idx*ADDR_W +: ADDR_W];
      bus.rf_we1   = bus.req_we[g1_idx];
      if (bus.req_we[g1_idx]) bus.rf_din1 = bus.req_wdata[g1_idx*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Capture read data for granted reads; pointer moves past the last grant.
  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (g0_vld && !bus.req_we[g0_idx]) begin
      rsp_valid_d[g0_idx] = 1'b1;
      rsp_rdata_d[g0_idx*WORD_SIZE +: WORD_SIZE] = bus.rf_dout0;
    end
    if (g1_vld && !bus.req_we[g1_idx]) begin
      rsp_valid_d[g1_idx] = 1'b1;
      rsp_rdata_d[g1_idx*WORD_SIZE +: WORD_SIZE] = bus.rf_dout1;
    end
    last_idx = g1_vld ? g1_idx : g0_idx;
    rr_ptr_d = rr_ptr_q;
    if (g0_vld) begin
      if (32'(last_idx) == NUM_REQ - 1) rr_ptr_d = '0;
      else rr_ptr_d = last_idx + PTR_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Bench for regfile_port_sched: vector table plus read-response scoreboard.
module tb_regfile_port_sched;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;
  localparam int unsigned A = 4;

  typedef logic [127:0] wide_t;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N-1:0]   we;
    logic [N*A-1:0] addr;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   exp_ready;
    int             p0;
    int             p1;
  } vec_t;

  typedef struct {
    int          who;
    logic [W-1:0] data;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_port_sched_if #(.NUM_REQ(N), .WORD_SIZE(W), .ADDR_W(A)) bus ();

  regfile_port_sched #(.NUM_REQ(N), .WORD_SIZE(W), .ADDR_W(A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file behind the ports: writes at the edge, combinational reads.
  logic [W-1:0] mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (bus.rf_we0) mem[bus.rf_addr0] <= bus.rf_din0;
    if (bus.rf_we1) mem[bus.rf_addr1] <= bus.rf_din1;
  end
  assign bus.rf_dout0 = mem[bus.rf_addr0];
  assign bus.rf_dout1 = mem[bus.rf_addr1];

  logic [W-1:0]   ref_mem [16] = '{default: '0};
  logic [N*W-1:0] exp_rdata = '0;
  sb_t            sb_q [$];
  vec_t           vecs [$];
  int             cyc = 0;
  int             tests = 0;
  int             fails = 0;

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] valid, input logic [N-1:0] we,
                              input logic [N*A-1:0] addr, input logic [N*W-1:0] wdata,
                              input logic [N-1:0] rdy, input int p0, input int p1);
    vec_t v;
    v.valid = valid;
    v.we = we;
    v.addr = addr;
    v.wdata = wdata;
    v.exp_ready = rdy;
    v.p0 = p0;
    v.p1 = p1;
    return v;
  endfunction

  function automatic wide_t port_exp(input vec_t v, input int p);
    if (p < 0) return '0;
    return wide_t'({v.addr[p*A +: A], v.we[p], v.we[p] ? v.wdata[p*W +: W] : 32'h0});
  endfunction

  task automatic push_read(input vec_t v, input int p);
    sb_t e;
    if (p < 0 || v.we[p]) return;
    e.who = p;
    e.data = ref_mem[v.addr[p*A +: A]];
    e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic apply_write(input vec_t v, input int p);
    if (p < 0 || !v.we[p]) return;
    ref_mem[v.addr[p*A +: A]] = v.wdata[p*W +: W];
  endtask

  task automatic check_rsp();
    logic [N-1:0] exp_v;
    sb_t e;
    exp_v = '0;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      exp_v[e.who] = 1'b1;
      exp_rdata[e.who*W +: W] = e.data;
    end
    chk("rsp_valid", wide_t'(bus.rsp_valid), wide_t'(exp_v));
    chk("rsp_rdata", wide_t'(bus.rsp_rdata), wide_t'(exp_rdata));
  endtask

  // One cycle: drive after the edge, predict, compare mid-cycle.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    bus.req_valid = v.valid;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    cyc++;
    // Reads see the pre-edge contents, so record them before this cycle's writes.
    push_read(v, v.p0);
    push_read(v, v.p1);
    apply_write(v, v.p0);
    apply_write(v, v.p1);
    @(negedge clk);
    chk("req_ready", wide_t'(bus.req_ready), wide_t'(v.exp_ready));
    chk("port0", wide_t'({bus.rf_addr0, bus.rf_we0, bus.rf_din0}), port_exp(v, v.p0));
    chk("port1", wide_t'({bus.rf_addr1, bus.rf_we1, bus.rf_din1}), port_exp(v, v.p1));
    check_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mk(4'b0000, 4'b0000, 16'h0, '0, 4'b0000, -1, -1);

    // Reset with everyone requesting: nothing may be granted or written.
    bus.req_valid = 4'b1111;
    bus.req_we    = 4'b0000;
    bus.req_addr  = 16'h4321;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", wide_t'(bus.req_ready), '0);
    chk("rst_we", wide_t'({bus.rf_we1, bus.rf_we0}), '0);
    chk("rst_ports", wide_t'({bus.rf_addr1, bus.rf_din1, bus.rf_addr0, bus.rf_din0}), '0);
    chk("rst_rsp_valid", wide_t'(bus.rsp_valid), '0);
    chk("rst_rsp_rdata", wide_t'(bus.rsp_rdata), '0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Fairness: all read, grants alternate {0,1} and {2,3}.
    vecs.push_back(mk(4'b1111, 4'b0000, 16'h4321, '0, 4'b0011, 0, 1));
    vecs.push_back(mk(4'b1111, 4'b0000, 16'h4321, '0, 4'b1100, 2, 3));
    vecs.push_back(mk(4'b1111, 4'b0000, 16'h4321, '0, 4'b0011, 0, 1));
    vecs.push_back(mk(4'b1111, 4'b0000, 16'h4321, '0, 4'b1100, 2, 3));
    // Write R5 by req 2, then read R5 by req 3.
    vecs.push_back(mk(4'b0100, 4'b0100, 16'h0500, {32'h0, 32'hDEADBEEF, 64'h0}, 4'b0100, 2, -1));
    vecs.push_back(mk(4'b1000, 4'b0000, 16'h5000, '0, 4'b1000, 3, -1));
    // Same-address write conflict on R7; req 2 read of R3 takes port 1.
    vecs.push_back(mk(4'b0111, 4'b0011, 16'h0377, {64'h0, 32'h22, 32'h11}, 4'b0101, 0, 2));
    vecs.push_back(mk(4'b0010, 4'b0010, 16'h0070, {64'h0, 32'h22, 32'h0}, 4'b0010, 1, -1));
    vecs.push_back(mk(4'b0001, 4'b0000, 16'h0007, '0, 4'b0001, 0, -1));
    // R4 = 0xA, then write 0xB while req 1 reads it in the same cycle.
    vecs.push_back(mk(4'b0001, 4'b0001, 16'h0004, {96'h0, 32'hA}, 4'b0001, 0, -1));
    vecs.push_back(mk(4'b0011, 4'b0001, 16'h0044, {96'h0, 32'hB}, 4'b0011, 1, 0));
    // Back-to-back reads by req 1.
    vecs.push_back(mk(4'b0010, 4'b0000, 16'h0040, '0, 4'b0010, 1, -1));
    vecs.push_back(mk(4'b0010, 4'b0000, 16'h0040, '0, 4'b0010, 1, -1));
    vecs.push_back(mk(4'b0010, 4'b0000, 16'h0070, '0, 4'b0010, 1, -1));
    vecs.push_back(idle);
    // Conflict with no other requester: port 1 stays idle.
    vecs.push_back(mk(4'b1100, 4'b1100, 16'h9900, {32'h98, 32'h99, 64'h0}, 4'b0100, 2, -1));
    vecs.push_back(mk(4'b1000, 4'b1000, 16'h9000, {32'h98, 96'h0}, 4'b1000, 3, -1));
    vecs.push_back(mk(4'b0010, 4'b0000, 16'h0090, '0, 4'b0010, 1, -1));
    vecs.push_back(mk(4'b0010, 4'b0000, 16'h0090, '0, 4'b0010, 1, -1));
    vecs.push_back(idle);

    foreach (vecs[i]) apply(vecs[i]);
    apply(idle);

    // Reset asserted during req 1's read grant cycle: no response afterwards.
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0010;
    bus.req_we    = 4'b0000;
    bus.req_addr  = 16'h0040;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", wide_t'(bus.req_ready), '0);
    chk("midrst_we", wide_t'({bus.rf_we1, bus.rf_we0}), '0);
    @(posedge clk);
    #1;
    chk("midrst_rsp_valid", wide_t'(bus.rsp_valid), '0);
    chk("midrst_rsp_rdata", wide_t'(bus.rsp_rdata), '0);
    bus.req_valid = '0;
    exp_rdata = '0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Pointer was at 2 before reset; it must restart at requester 0.
    apply(mk(4'b1111, 4'b0000, 16'h9754, '0, 4'b0011, 0, 1));
    apply(idle);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_port_sched.md
# regfile_port_sched

Schedules up to NUM_REQ independent requesters (fetch/decode operand reads, writeback, debug/monitor) onto the two shared read/write ports of the 16 x 32-bit dual-port register file. Each cycle it grants at most two requests in round-robin order, drives the register-file port signals, and returns read data to the granted requester one cycle later. It sits between the pipeline stages and the register file and is the only block that drives the register-file ports.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- WORD_SIZE, 32: data width.
- ADDR_W, 4: register address width (16 registers).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  register address; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*WORD_SIZE  write data, sliced the same way.
- req_ready  out  NUM_REQ  grant; a request is accepted when valid and ready are both 1.
- rsp_valid  out  NUM_REQ  one-cycle pulse: read data for requester i is available.
- rsp_rdata  out  NUM_REQ*WORD_SIZE  read data, held until that requester's next read response.
- rf_addr0, rf_addr1  out  ADDR_W  register-file port addresses.
- rf_din0, rf_din1  out  WORD_SIZE  register-file write data.
- rf_we0, rf_we1  out  1  register-file write enables.
- rf_dout0, rf_dout1  in  WORD_SIZE  combinational register-file read data.

## Operation
- Round-robin pointer rr_ptr, range 0..NUM_REQ-1, reset to 0.
- Each cycle, scan requesters in the order rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - The first valid requester found is granted port 0.
  - The next eligible valid requester is granted port 1.
  - No requester receives more than one port.
- Eligibility for port 1:
  - A write is ineligible if port 0 holds a write to the same address; the scan skips it and continues.
  - Reads are always eligible.
- req_ready is combinational:
  - It is 1 only for granted requesters.
  - It does not depend on the requester's own req_ready (no loop).
  - A requester must hold valid, we, addr and wdata stable until granted.
- Port drive:
  - Granted port: rf_addrN = requester addr; rf_weN = requester we; rf_dinN = requester wdata (0 when the grant is a read).
  - Ungranted port: rf_addrN = 0, rf_weN = 0, rf_dinN = 0.
- Read grant: rf_doutN is captured at the grant edge into rsp_rdata[i], and rsp_valid[i] is set for exactly one cycle.
- Same-cycle read and write to the same address: the read returns the old value (write-after-read ordering within the cycle).
- Pointer update on any grant: rr_ptr <= (index of the last granted requester + 1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/2) cycles, except for repeated same-address write conflicts, which are bounded by NUM_REQ cycles.

## Timing
- Request to register-file port: combinational, same cycle.
- Write takes effect at the grant edge.
- Read latency: the grant occurs in cycle T; rsp_valid and rsp_rdata are valid in cycle T+1.
- Throughput: 2 accesses per cycle.
- A requester may issue back-to-back reads. rsp_valid then stays high on consecutive cycles, each with new data.
- Reset (rst_n low, asynchronous):
  - rr_ptr = 0, rsp_valid = 0, rsp_rdata = 0.
  - req_ready = 0 and rf_we0 = rf_we1 = 0 while rst_n is low.
  - rf_addr and rf_din = 0.
- Reset mid-operation: a read granted in the cycle reset asserts produces no response, and pending requests are dropped. After rst_n deasserts, the first grant starts from requester 0.
- Reset release: the first edge after rst_n rises may grant.

## Test plan
- Reset check:
  - Stimulus: rst_n low with req_valid=4'b1111.
  - Required: req_ready=0, rf_we0/1=0, rsp_valid=0, rsp_rdata=0.
  - After release, the first grants are requesters 0 (port 0) and 1 (port 1).
- Write then read:
  - Stimulus: requester 2 writes R5=0xDEADBEEF, then requester 3 reads R5 next cycle.
  - Required: rsp_valid[3] pulses one cycle later with 0xDEADBEEF.
- Same-address write conflict:
  - Stimulus: requesters 0 and 1 both write R7 (0x11, 0x22) and requester 2 reads R3.
  - Required in the same cycle: port0=req0 write, port1=req2 read, req_ready=4'b0101.
  - Required next cycle: req1 is granted, and R7 ends at 0x22.
- Read/write same cycle:
  - Stimulus: R4 holds 0xA; requester 0 writes R4=0xB while requester 1 reads R4.
  - Required: rsp_rdata[1]=0xA; a following read returns 0xB.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously read distinct registers.
  - Required: grants are {0,1}, {2,3}, {0,1}…, and rsp_valid pulses match the grants each cycle.
- Reset mid-read:
  - Stimulus: rst_n asserted in the grant cycle of requester 1's read.
  - Required: no rsp_valid[1] pulse, and rr_ptr returns to 0.
